// File: rtl/samDefines.sv
// rtl/samDefines.sv - shared widths, write-word command codes and sequencer state type
package samDefines;
    localparam int DEF_TGT_BITS      = 32;
    localparam int DEF_WORDS_PER_ROW = 32;
    localparam int DEF_BRAM_ADR_BITS = 5;

    localparam logic [1:0] WR_IDLE    = 2'b00;
    localparam logic [1:0] WR_PREPARE = 2'b01;
    localparam logic [1:0] WR_UPDATE  = 2'b10;
    localparam logic [1:0] WR_COMMIT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_PREP   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;
endpackage

// File: rtl/WriteWord.sv
// rtl/WriteWord.sv - row buffer that loads a BRAM row and patches one word into it
module WriteWord
    import samDefines::*;
#(
    parameter int TGT_BITS      = DEF_TGT_BITS,
    parameter int BRAM_ADR_BITS = DEF_BRAM_ADR_BITS,
    parameter int ROW_BITS      = DEF_WORDS_PER_ROW * TGT_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               wrytGo,
    input  logic [ROW_BITS-1:0]      rowIn,
    input  logic [BRAM_ADR_BITS-1:0] wdAdr,
    input  logic [TGT_BITS-1:0]      target,
    output logic [ROW_BITS-1:0]      rowOut
);
    logic [ROW_BITS-1:0] row_q;

    // COMMIT simply holds the patched row so the sequencer can write it back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else begin
            case (wrytGo)
                WR_PREPARE: row_q <= rowIn;
                WR_UPDATE:  row_q[int'(wdAdr) * TGT_BITS +: TGT_BITS] <= target;
                default:    row_q <= row_q;
            endcase
        end
    end

    assign rowOut = row_q;
endmodule

// File: rtl/row_write_seq.sv
// rtl/row_write_seq.sv - read-modify-write sequencer committing one word per request into a BRAM row
module row_write_seq
    import samDefines::*;
#(
    parameter int TGT_BITS      = DEF_TGT_BITS,
    parameter int ROW_BITS      = DEF_WORDS_PER_ROW * TGT_BITS,
    parameter int BRAM_ADR_BITS = DEF_BRAM_ADR_BITS,
    parameter int ROW_ADR_BITS  = 10,
    parameter int NUM_ROWS      = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic [ROW_ADR_BITS-1:0]  reqRow,
    input  logic [BRAM_ADR_BITS-1:0] reqWdAdr,
    input  logic [TGT_BITS-1:0]      reqTarget,
    output logic                     bramRdEn,
    output logic                     bramWrEn,
    output logic [ROW_ADR_BITS-1:0]  bramAdr,
    input  logic [ROW_BITS-1:0]      bramRdData,
    output logic [ROW_BITS-1:0]      bramWrData,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic [15:0]              wrCount
);
    state_t                   state;
    logic [1:0]               wrytGo;
    logic [ROW_ADR_BITS-1:0]  row_q;
    logic [BRAM_ADR_BITS-1:0] wd_q;
    logic [TGT_BITS-1:0]      tgt_q;
    logic [15:0]              wr_count_q;

    // Outputs are registered with the state, so each output shows the value
    // belonging to the state the FSM is in during that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            reqReady   <= 1'b1;
            bramRdEn   <= 1'b0;
            bramWrEn   <= 1'b0;
            bramAdr    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            wrytGo     <= WR_IDLE;
            wr_count_q <= '0;
            row_q      <= '0;
            wd_q       <= '0;
            tgt_q      <= '0;
        end else begin
            bramRdEn <= 1'b0;
            bramWrEn <= 1'b0;
            bramAdr  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            wrytGo   <= WR_IDLE;
            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        if (32'(reqRow) < 32'(NUM_ROWS)) begin
                            row_q    <= reqRow;
                            wd_q     <= reqWdAdr;
                            tgt_q    <= reqTarget;
                            state    <= ST_READ;
                            reqReady <= 1'b0;
                            busy     <= 1'b1;
                            bramRdEn <= 1'b1;
                            bramAdr  <= reqRow;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state  <= ST_PREP;
                    wrytGo <= WR_PREPARE;
                end
                ST_PREP: begin
                    state  <= ST_UPDATE;
                    wrytGo <= WR_UPDATE;
                end
                ST_UPDATE: begin
                    state      <= ST_COMMIT;
                    wrytGo     <= WR_COMMIT;
                    bramWrEn   <= 1'b1;
                    bramAdr    <= row_q;
                    done       <= 1'b1;
                    wr_count_q <= wr_count_q + 16'd1;
                end
                ST_COMMIT: begin
                    state    <= ST_IDLE;
                    reqReady <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    reqReady <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign wrCount = wr_count_q;

    WriteWord #(
        .TGT_BITS      (TGT_BITS),
        .BRAM_ADR_BITS (BRAM_ADR_BITS),
        .ROW_BITS      (ROW_BITS)
    ) u_write_word (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrytGo (wrytGo),
        .rowIn  (bramRdData),
        .wdAdr  (wd_q),
        .target (tgt_q),
        .rowOut (bramWrData)
    );
endmodule

// File: tb/tb_row_write_seq.sv
// tb/tb_row_write_seq.sv - self-checking bench for row_write_seq with a BRAM model and write scoreboard
module tb_row_write_seq;
    localparam int TB_ROWS = 16;

    typedef struct packed {
        logic [9:0]    row;
        logic [1023:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [9:0]    reqRow = '0;
    logic [4:0]    reqWdAdr = '0;
    logic [31:0]   reqTarget = '0;
    logic          bramRdEn;
    logic          bramWrEn;
    logic [9:0]    bramAdr;
    logic [1023:0] bramRdData = '0;
    logic [1023:0] bramWrData;
    logic          done;
    logic          err;
    logic          busy;
    logic [15:0]   wrCount;

    logic          load_en = 1'b0;
    logic [3:0]    load_row = '0;
    logic [1023:0] load_data = '0;
    logic [1023:0] mem   [TB_ROWS];
    logic [1023:0] model [TB_ROWS];
    wr_t           exp_q [$];
    wr_t           got_q [$];
    int            checks = 0;
    int            failures = 0;
    int            overlap = 0;
    int            idle_adr_bad = 0;
    logic [15:0]   exp_count = '0;

    always #5 clk = ~clk;

    row_write_seq #(.NUM_ROWS(TB_ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqRow     (reqRow),
        .reqWdAdr   (reqWdAdr),
        .reqTarget  (reqTarget),
        .bramRdEn   (bramRdEn),
        .bramWrEn   (bramWrEn),
        .bramAdr    (bramAdr),
        .bramRdData (bramRdData),
        .bramWrData (bramWrData),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .wrCount    (wrCount)
    );

    always @(posedge clk) begin
        if (bramRdEn) bramRdData <= mem[bramAdr[3:0]];
        if (bramWrEn) mem[bramAdr[3:0]] <= bramWrData;
        if (load_en)  mem[load_row] <= load_data;
    end

    always @(negedge clk) begin
        if (bramWrEn) got_q.push_back({bramAdr, bramWrData});
        if (bramRdEn && bramWrEn) overlap++;
        if (!busy && bramAdr != 10'd0) idle_adr_bad++;
    end

    function automatic logic [1023:0] fill(input logic [31:0] w);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = w;
        return r;
    endfunction

    task automatic preload(input logic [3:0] row, input logic [1023:0] data);
        @(negedge clk);
        load_en = 1'b1; load_row = row; load_data = data;
        model[row] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic drive_req(input logic v, input logic [9:0] r, input logic [4:0] w, input logic [31:0] t);
        reqValid = v; reqRow = r; reqWdAdr = w; reqTarget = t;
    endtask

    task automatic expect_write(input logic [9:0] r, input logic [4:0] w, input logic [31:0] t);
        logic [1023:0] e;
        e = model[r[3:0]];
        e[int'(w)*32 +: 32] = t;
        model[r[3:0]] = e;
        exp_q.push_back({r, e});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_req(1'b0, 10'd0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if ({reqReady, bramRdEn, bramWrEn, done, err, busy} !== 6'b100000) begin
            failures++; $display("FAIL reset_flags got=%b exp=100000", {reqReady, bramRdEn, bramWrEn, done, err, busy});
        end
        checks++;
        if (bramAdr !== 10'd0 || wrCount !== 16'd0) begin
            failures++; $display("FAIL reset_adr_count adr=%0d count=%0d exp=0,0", bramAdr, wrCount);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", reqReady); end
    endtask

    task automatic test_single;
        wr_t g, e;
        int bad;
        preload(4'd5, fill(32'hAAAAAAAA));
        @(negedge clk);
        drive_req(1'b1, 10'd5, 5'd3, 32'h12345678);
        expect_write(10'd5, 5'd3, 32'h12345678);
        checks++;
        if (reqReady !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", reqReady); end
        @(negedge clk);
        drive_req(1'b0, 10'd0, 5'd0, 32'd0);
        checks++;
        if (!(bramRdEn === 1'b1 && bramWrEn === 1'b0 && bramAdr === 10'd5 && busy === 1'b1)) begin
            failures++; $display("FAIL single_read rd=%b wr=%b adr=%0d busy=%b exp=1,0,5,1", bramRdEn, bramWrEn, bramAdr, busy);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bramRdEn !== 1'b0 || bramWrEn !== 1'b0 || done !== 1'b0 || reqReady !== 1'b0) begin
                failures++; $display("FAIL single_mid rd=%b wr=%b done=%b ready=%b exp=0,0,0,0", bramRdEn, bramWrEn, done, reqReady);
            end
        end
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++;
        if (!(bramWrEn === 1'b1 && done === 1'b1 && bramAdr === 10'd5 && wrCount === exp_count)) begin
            failures++; $display("FAIL single_commit wr=%b done=%b adr=%0d count=%0d exp=1,1,5,%0d", bramWrEn, done, bramAdr, wrCount, exp_count);
        end
        @(negedge clk);
        checks++;
        if (!(reqReady === 1'b1 && busy === 1'b0 && bramAdr === 10'd0 && done === 1'b0)) begin
            failures++; $display("FAIL single_idle ready=%b busy=%b adr=%0d done=%b exp=1,0,0,0", reqReady, busy, bramAdr, done);
        end
        checks++;
        if (got_q.size() == 0) begin
            failures++; $display("FAIL single_scoreboard got=no_write exp=write");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin failures++; $display("FAIL single_scoreboard got_row=%0d exp_row=%0d data_equal=%0b", g.row, e.row, g.data === e.data); end
        end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (mem[5][i*32 +: 32] !== ((i == 3) ? 32'h12345678 : 32'hAAAAAAAA)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL single_row_words bad_words=%0d exp=0", bad); end
    endtask

    task automatic test_back_to_back;
        logic [1023:0] pre;
        wr_t g, e;
        int bad;
        for (int i = 0; i < 32; i++) pre[i*32 +: 32] = 32'h70000000 + 32'(i);
        preload(4'd7, pre);
        @(negedge clk);
        drive_req(1'b1, 10'd7, 5'd0, 32'hCAFE0000);
        expect_write(10'd7, 5'd0, 32'hCAFE0000);
        repeat (4) @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++;
        if (done !== 1'b1 || wrCount !== exp_count) begin
            failures++; $display("FAIL b2b_first_commit done=%b count=%0d exp=1,%0d", done, wrCount, exp_count);
        end
        drive_req(1'b1, 10'd7, 5'd31, 32'h0BAD0031);
        expect_write(10'd7, 5'd31, 32'h0BAD0031);
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1) begin failures++; $display("FAIL b2b_ready_t5 got=%b exp=1", reqReady); end
        @(negedge clk);
        drive_req(1'b0, 10'd0, 5'd0, 32'd0);
        checks++;
        if (bramRdEn !== 1'b1 || bramAdr !== 10'd7) begin
            failures++; $display("FAIL b2b_second_read rd=%b adr=%0d exp=1,7", bramRdEn, bramAdr);
        end
        repeat (3) @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++;
        if (done !== 1'b1 || bramWrEn !== 1'b1 || wrCount !== exp_count) begin
            failures++; $display("FAIL b2b_second_commit done=%b wr=%b count=%0d exp=1,1,%0d", done, bramWrEn, wrCount, exp_count);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL b2b_scoreboard_%0d got=no_write exp=write", k);
            end else begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL b2b_scoreboard_%0d got_row=%0d exp_row=%0d data_equal=%0b", k, g.row, e.row, g.data === e.data); end
            end
        end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (mem[7][i*32 +: 32] !== ((i == 0) ? 32'hCAFE0000 : (i == 31) ? 32'h0BAD0031 : 32'h70000000 + 32'(i))) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL b2b_row_words bad_words=%0d exp=0", bad); end
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        drive_req(1'b1, 10'(TB_ROWS), 5'd1, 32'h55AA55AA);
        @(negedge clk);
        drive_req(1'b0, 10'd0, 5'd0, 32'd0);
        checks++;
        if (!(err === 1'b1 && reqReady === 1'b1 && bramRdEn === 1'b0 && bramWrEn === 1'b0 && busy === 1'b0)) begin
            failures++; $display("FAIL oor_err err=%b ready=%b rd=%b wr=%b busy=%b exp=1,1,0,0,0", err, reqReady, bramRdEn, bramWrEn, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || bramRdEn !== 1'b0 || wrCount !== exp_count) begin
            failures++; $display("FAIL oor_after err=%b rd=%b count=%0d exp=0,0,%0d", err, bramRdEn, wrCount, exp_count);
        end
    endtask

    task automatic test_reset_mid_op;
        wr_t g, e;
        int n;
        preload(4'd9, fill(32'h55555555));
        @(negedge clk);
        drive_req(1'b1, 10'd9, 5'd4, 32'h99999999);
        @(negedge clk);
        drive_req(1'b0, 10'd0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({reqReady, bramRdEn, bramWrEn, done, err, busy} !== 6'b100000 || bramAdr !== 10'd0 || wrCount !== 16'd0) begin
            failures++; $display("FAIL midrst_outputs flags=%b adr=%0d count=%0d exp=100000,0,0", {reqReady, bramRdEn, bramWrEn, done, err, busy}, bramAdr, wrCount);
        end
        exp_count = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem[9] !== fill(32'h55555555) || got_q.size() != 0) begin
            failures++; $display("FAIL midrst_row_kept row_equal=%0b writes=%0d exp=1,0", mem[9] === fill(32'h55555555), got_q.size());
        end
        drive_req(1'b1, 10'd9, 5'd17, 32'h0F0F1234);
        expect_write(10'd9, 5'd17, 32'h0F0F1234);
        @(negedge clk);
        drive_req(1'b0, 10'd0, 5'd0, 32'd0);
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        exp_count = exp_count + 16'd1;
        checks++;
        if (done !== 1'b1 || wrCount !== exp_count) begin
            failures++; $display("FAIL midrst_recover done=%b count=%0d exp=1,%0d", done, wrCount, exp_count);
        end
        @(negedge clk);
        checks++;
        if (got_q.size() == 0) begin
            failures++; $display("FAIL midrst_scoreboard got=no_write exp=write");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin failures++; $display("FAIL midrst_scoreboard got_row=%0d exp_row=%0d data_equal=%0b", g.row, e.row, g.data === e.data); end
        end
    endtask

    task automatic test_wrap_and_ignore;
        wr_t g, e;
        int n;
        preload(4'd2, fill(32'h22222222));
        @(negedge clk);
        force dut.wr_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.wr_count_q;
        exp_count = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_req(1'b1, 10'd2, 5'(5 + k), 32'hDEADBEEF + 32'(k));
            expect_write(10'd2, 5'(5 + k), 32'hDEADBEEF + 32'(k));
            @(negedge clk);
            n = 0;
            while (!done && n < 10) begin
                reqRow    = 10'($urandom_range(0, 31));
                reqWdAdr  = 5'($urandom_range(0, 31));
                reqTarget = $urandom;
                @(negedge clk);
                n++;
            end
            reqValid = 1'b0;
            exp_count = exp_count + 16'd1;
            checks++;
            if (done !== 1'b1 || bramAdr !== 10'd2 || wrCount !== exp_count) begin
                failures++; $display("FAIL wrap_commit_%0d done=%b adr=%0d count=%0d exp=1,2,%0d", k, done, bramAdr, wrCount, exp_count);
            end
            @(negedge clk);
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL wrap_scoreboard_%0d got=no_write exp=write", k);
            end else begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL wrap_scoreboard_%0d got_row=%0d exp_row=%0d data_equal=%0b", k, g.row, e.row, g.data === e.data); end
            end
        end
        checks++;
        if (wrCount !== 16'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", wrCount); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_op();
        test_wrap_and_ignore();
        checks++;
        if (overlap != 0 || idle_adr_bad != 0) begin
            failures++; $display("FAIL strobe_rules overlap=%0d idle_adr_nonzero=%0d exp=0,0", overlap, idle_adr_bad);
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain exp_left=%0d got_left=%0d exp=0,0", exp_q.size(), got_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
